shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, data width in bits.
REQ-002 SHALL have parameter AMT_W, default 3, shift-amount field width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous flush to IDLE.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_data  input  WIDTH  operand.
REQ-009 SHALL have port cmd_dir  input  1  direction: 0 = right, 1 = left.
REQ-010 SHALL have port cmd_amt  input  AMT_W  shift count.
REQ-011 SHALL have port res_valid  output  1  result available.
REQ-012 SHALL have port res_ready  input  1  result consumed when high with res_valid.
REQ-013 SHALL have port res_data  output  WIDTH  shifted result.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done_cnt  output  8  count of completed result handshakes.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL assert cmd_ready only in IDLE; commands are accepted only there.
REQ-018 On accept, SHALL load cmd_data into the shift register, latch cmd_dir, and load the count register with min(cmd_amt, WIDTH).
REQ-019 After accept, SHALL go to SHIFT if the clamped count is nonzero; otherwise go to DONE.
REQ-020 In SHIFT, SHALL shift exactly one bit per cycle, logical with zero fill, in the latched direction, and decrement the count.
REQ-021 SHALL go SHIFT->DONE on the edge that performs the last shift.
REQ-022 Latency: res_valid SHALL rise exactly N edges after the accept edge, where N is the clamped count; N=0 gives res_valid on the cycle after accept.
REQ-023 cmd_amt > WIDTH SHALL saturate to WIDTH shifts, giving an all-zero result.
REQ-024 In DONE, SHALL hold res_valid high and res_data stable until res_ready; on handshake, SHALL go to IDLE and increment done_cnt, wrapping 255->0.
REQ-025 A new command SHALL NOT be accepted on the same edge as a result handshake; cmd_ready rises the cycle after.
REQ-026 cmd_data, cmd_dir and cmd_amt changes SHALL have no effect outside the accept edge.
REQ-027 clr SHALL have priority over all handshakes: next state IDLE, count cleared, res_valid low, done_cnt unchanged, shift-register contents don't-care.
REQ-028 res_data SHALL equal the shift-register value in every state; only res_valid qualifies it.

Reset
REQ-029 While rst_n is low, SHALL hold: state IDLE, shift register 0, count 0, dir 0, done_cnt 0, res_valid 0, res_data 0, busy 0, cmd_ready 1.
REQ-030 Reset mid-SHIFT or mid-DONE SHALL abandon the operation with no handshake and no done_cnt increment.
REQ-031 SHALL accept a command on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package shift_seq_pkg SHALL hold the FSM state enum and the constants DIR_RIGHT=0 and DIR_LEFT=1.
REQ-033 The datapath SHALL be one sub-module, shift_stage: a WIDTH-bit register with load, one-bit-right and one-bit-left controls, priority load > right > left, hold otherwise.
REQ-034 The FSM, count register and done_cnt SHALL reside in shift_sequencer.

Verification
REQ-035 Left-shift: accept 5'b10110, left, amt 1, res_ready=1 -> res_valid 1 edge after accept, res_data 5'b01100, done_cnt 1.
REQ-036 Right-shift: accept 5'b10110, right, amt 3 -> res_data 5'b00010 after 3 SHIFT cycles; busy high from accept to handshake.
REQ-037 Zero and saturation: amt 0 on 5'b10110 -> 5'b10110 on the next cycle; amt 7 -> 5 shifts, then 5'b00000.
REQ-038 Backpressure: hold res_ready low for 4 cycles in DONE -> res_valid and res_data stable and cmd_ready low throughout; IDLE the cycle after handshake.
REQ-039 Abort: assert clr, then separately pulse rst_n low, each during SHIFT with amt 4 -> IDLE next edge (clr) or immediately (rst_n), no res_valid, done_cnt unchanged (clr) or 0 (rst_n).
REQ-040 Wrap: 256 back-to-back amt-0 commands -> done_cnt returns to 0.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_seq_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Encoding of the direction input.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Limits a requested shift count to the data width.
    // Shifting further than that would only produce zeros anyway.
    function automatic int unsigned clamp_amt(input int unsigned amt, input int unsigned width);
        return (amt > width) ? width : amt;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Datapath register for the shift sequencer.
// Each cycle it does one of: parallel load, one-bit logical right shift,
// one-bit logical left shift, or hold. If more than one control is high,
// load wins over right, and right wins over left.
module shift_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shr_i,
    input  logic             shl_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Choose the next register value, highest-priority control first.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shr_i) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
        end else if (shl_i) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register update; reset clears the contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command/result wrapper around a one-bit-per-cycle shifter.
// It takes a command in IDLE and shifts the operand one bit per cycle until
// the count is used up. It then holds the result in DONE until that result
// is consumed, and counts every completed result handshake.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [AMT_W-1:0] cmd_amt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [7:0]       done_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic             load;
    logic             shr;
    logic             shl;
    logic [CNT_W-1:0] amt_clamped;

    assign amt_clamped = CNT_W'(clamp_amt(32'(cmd_amt), WIDTH));

    // Next-state logic and datapath controls. A flush overrides every handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        done_cnt_d = done_cnt_q;
        load       = 1'b0;
        shr        = 1'b0;
        shl        = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        load    = 1'b1;
                        dir_d   = cmd_dir;
                        cnt_d   = amt_clamped;
                        state_d = (amt_clamped != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    shr   = (dir_q == DIR_RIGHT);
                    shl   = (dir_q == DIR_LEFT);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d    = IDLE;
                        done_cnt_d = done_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= DIR_RIGHT;
            done_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (cmd_data),
        .shr_i       (shr),
        .shl_i       (shl),
        .data_o      (res_data)
    );

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;

endmodule
